serial_subtractor: RTL

//  Bit-serial WIDTH-bit subtractor: diff = a - b - b_in, computed LSB-first.
//  One full-subtractor cell plus a borrow flip-flop handles one bit per cycle.

---
 rtl/serial_subtractor.sv | 114 +++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b - b_in), LSB-first, one bit per clock.
// Define SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             b_out
`ifdef SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] res_q;
   logic             br_q;
   logic [CNT_W-1:0] cnt_q;

   logic             d_bit_d;
   logic             br_d;
   logic [WIDTH-1:0] res_d;

   // Full-subtractor cell on the current LSBs; the result fills from the MSB end.
   assign d_bit_d = a_q[0] ^ b_q[0] ^ br_q;
   assign br_d    = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
   assign res_d   = {d_bit_d, res_q[WIDTH-1:1]};

`ifdef SUB_OVF_EN
   logic a_msb_q;
   logic b_msb_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         br_q    <= 1'b0;
         cnt_q   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         diff    <= '0;
         b_out   <= 1'b0;
`ifdef SUB_OVF_EN
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         ovf     <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_q     <= a;
                  b_q     <= b;
                  br_q    <= b_in;
                  res_q   <= '0;
                  cnt_q   <= '0;
                  busy    <= 1'b1;
                  state_q <= BUSY;
`ifdef SUB_OVF_EN
                  a_msb_q <= a[WIDTH-1];
                  b_msb_q <= b[WIDTH-1];
`endif
               end
            end
            BUSY: begin
               a_q   <= a_q >> 1;
               b_q   <= b_q >> 1;
               br_q  <= br_d;
               res_q <= res_d;
               cnt_q <= cnt_q + 1'b1;
               // Ports only change here, so intermediate shifting stays hidden.
               if (cnt_q == LAST) begin
                  state_q <= DONE;
                  done    <= 1'b1;
                  diff    <= res_d;
                  b_out   <= br_d;
`ifdef SUB_OVF_EN
                  ovf     <= (a_msb_q ^ b_msb_q) & (d_bit_d ^ a_msb_q);
`endif
               end
            end
            DONE: begin
               state_q <= IDLE;
               done    <= 1'b0;
               busy    <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               done    <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
